// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO in front of an 8N1 serial transmitter.
// Each cycle with uart_we high queues one byte unless the FIFO is full.
// A dropped byte sets the sticky overflow flag.
// The FSM pops the head byte only from IDLE and shifts it out LSB first.
module uart_tx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    uart,
  input  logic                          uart_we,
  output logic                          txd,
  output logic                          busy,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             push;
  logic             pop;
  logic             tmr_done;

  // full comes from registered count, so a same-edge pop never frees space for a push
  assign full     = (count == CNT_FULL);
  assign push     = uart_we & ~full;
  assign pop      = (state == IDLE) & (count != '0);
  assign tmr_done = (timer == TMR_LAST);
  assign busy     = (count != '0) | (state != IDLE);

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= uart;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push && pop) begin
        count <= count - CNT_ONE;
      end
      if (uart_we && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Shift register: loaded on pop, shifted right at the end of each data bit
  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= mem[rd_ptr];
    end else if (state == DATA && tmr_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

  // Frame FSM with bit timer; txd is registered and tracks the next state's level
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      txd   <= 1'b1;
      timer <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
          end else begin
            txd   <= 1'b1;
          end
        end
        START: begin
          if (tmr_done) begin
            timer <= '0;
            state <= DATA;
            idx   <= '0;
            txd   <= shift[0];
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        DATA: begin
          if (tmr_done) begin
            timer <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              txd   <= shift[1];
            end
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (tmr_done) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A txd-only frame decoder collects received bytes and their start cycles.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart;
  logic       uart_we;
  logic       txd;
  logic       busy;
  logic       full;
  logic       overflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_buffer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart     (uart),
    .uart_we  (uart_we),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .overflow (overflow),
    .count    (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder: samples each bit mid-cell from the first low cycle of the start bit
  logic       rst_q   = 1'b1;
  logic       mon_act = 1'b0;
  int         mon_k   = 0;
  int         mon_t   = 0;
  logic [9:0] mon_sh  = '0;
  logic [9:0] word;
  logic [7:0] rx_q [$];
  logic       rx_ok [$];
  int         rx_t [$];

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst_q) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (txd === 1'b0) begin
        mon_act <= 1'b1;
        mon_k   <= 1;
        mon_t   <= cyc;
      end
    end else begin
      mon_k <= mon_k + 1;
      if (mon_k % 4 == 2) mon_sh <= {txd, mon_sh[9:1]};
      if (mon_k == 38) begin
        word = {txd, mon_sh[9:1]};
        rx_q.push_back(word[8:1]);
        rx_ok.push_back(word[0] == 1'b0 && word[9] == 1'b1);
        rx_t.push_back(mon_t);
        mon_act <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    uart    = b;
    uart_we = 1'b1;
    @(negedge clk);
    uart_we = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_ok.delete();
    rx_t.delete();
  endtask

  logic [9:0] lv;
  logic [7:0] exp6 [10];

  initial begin
    rst     = 1'b1;
    uart    = 8'h00;
    uart_we = 1'b0;

    // 1: reset held 3 cycles, then idle for 100 cycles
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", txd, 1);
      check("idle_busy", busy, 0);
      check("idle_count", count, 0);
      check("idle_ovf", overflow, 0);
    end

    // 2: single 0xA5 frame, every cycle checked
    clear_rx();
    push(8'hA5);
    check("a5_count_after_push", count, 1);
    check("a5_txd_before_pop", txd, 1);
    lv = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("a5_txd_bit", txd, lv[k/4]);
      if (k == 0) begin
        check("a5_count_popped", count, 0);
        check("a5_busy_frame", busy, 1);
      end
    end
    @(negedge clk);
    check("a5_busy_end", busy, 0);
    check("a5_txd_end", txd, 1);
    check("a5_rx_n", rx_q.size(), 1);
    check("a5_rx_byte", rx_q[0], 8'hA5);
    check("a5_rx_framing", rx_ok[0], 1);

    // 3: three consecutive pushes, count peak and 41-cycle period
    repeat (5) @(negedge clk);
    clear_rx();
    push(8'h01);
    check("t3_count1", count, 1);
    push(8'h02);
    check("t3_count2", count, 1);
    push(8'h03);
    check("t3_count3", count, 2);
    wait_rx(3, 300, "t3_rx_wait");
    if (rx_q.size() >= 3) begin
      check("t3_byte0", rx_q[0], 8'h01);
      check("t3_byte1", rx_q[1], 8'h02);
      check("t3_byte2", rx_q[2], 8'h03);
      check("t3_framing", {rx_ok[0], rx_ok[1], rx_ok[2]}, 3'b111);
      check("t3_period01", rx_t[1] - rx_t[0], 41);
      check("t3_period12", rx_t[2] - rx_t[1], 41);
    end
    repeat (5) @(negedge clk);
    check("t3_busy_end", busy, 0);

    // 4: six pushes into a 4-deep FIFO, last one dropped
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i));
      if (i == 4) begin
        check("t4_full", full, 1);
        check("t4_count_full", count, 4);
        check("t4_ovf_before", overflow, 0);
      end
      if (i == 5) begin
        check("t4_ovf_set", overflow, 1);
        check("t4_count_after_drop", count, 4);
      end
    end
    wait_rx(5, 600, "t4_rx_wait");
    repeat (60) @(negedge clk);
    check("t4_rx_n", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      check("t4_byte", rx_q[i], 8'h10 + 8'(i));
    end
    check("t4_ovf_sticky", overflow, 1);
    check("t4_busy_end", busy, 0);
    check("t4_full_end", full, 0);

    // 5: reset during data bit 3 with two bytes queued
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ovf_cleared", overflow, 0);
    repeat (2) @(negedge clk);
    clear_rx();
    push(8'hF0);
    push(8'h11);
    push(8'h22);
    check("t5_count_queued", count, 2);
    repeat (16) @(negedge clk);
    check("t5_txd_bit3", txd, 0);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_txd_rst", txd, 1);
    check("t5_count_rst", count, 0);
    check("t5_busy_rst", busy, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_frames", rx_q.size(), 0);
    check("t5_txd_idle", txd, 1);
    check("t5_busy_idle", busy, 0);

    // 6: ten bytes pushed and drained one at a time, pointers wrap
    clear_rx();
    for (int i = 0; i < 10; i++) begin
      exp6[i] = 8'h3C ^ 8'(i * 37);
      push(exp6[i]);
      wait_rx(i + 1, 100, "t6_rx_wait");
    end
    repeat (10) @(negedge clk);
    check("t6_rx_n", rx_q.size(), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      check("t6_byte", rx_q[i], exp6[i]);
      check("t6_framing", rx_ok[i], 1);
    end
    check("t6_busy_end", busy, 0);
    check("t6_count_end", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
